// File: rtl/tx_frame_arbiter_if.sv
// tx_frame_arbiter_if
//   Bundles the frame-source request bus and the transmitter control lines
//   that surround tx_frame_arbiter.
//   master : arbiter view (takes requests and stuffsend, drives transmitter
//            controls and the per-source completion pulses)
//   slave  : environment view (sources plus transmitter)
//   req/req_size/req_bits : NREQ sources, size 4 bits and data 128 bits each
//   stuffsend             : transmitter busy-on-line indication
//   tf/framesize/framebits: transmitter start and latched frame
//   ack/err/busy/grant_id : completion pulse, failure flag, status, grant index
interface tx_frame_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [4*NREQ-1:0]     req_size;
    logic [128*NREQ-1:0]   req_bits;
    logic                  stuffsend;
    logic                  tf;
    logic [3:0]            framesize;
    logic [127:0]          framebits;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic                  busy;
    logic [IW-1:0]         grant_id;

    modport master (
        input  req, req_size, req_bits, stuffsend,
        output tf, framesize, framebits, ack, err, busy, grant_id
    );

    modport slave (
        output req, req_size, req_bits, stuffsend,
        input  tf, framesize, framebits, ack, err, busy, grant_id
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//   Round-robin sharing of one serial frame transmitter among NREQ sources.
//   Latches the winner's size/data, drives tf until the transmitter raises
//   stuffsend (or a start timeout expires), then pulses ack (with err on
//   zero-size reject or start abort) and enforces an idle gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tx_frame_arbiter_if master modport (requests + transmitter)
module tx_frame_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tx_frame_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT);
    localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t          state_q, state_n;
    logic            tf_q, tf_n;
    logic [3:0]      size_q, size_n;
    logic [127:0]    bits_q, bits_n;
    logic [NREQ-1:0] ack_q, ack_n;
    logic            err_q, err_n;
    logic            busy_q, busy_n;
    logic [IW-1:0]   gid_q, gid_n;
    logic [IW-1:0]   rr_q, rr_n;
    logic [TW-1:0]   tcnt_q, tcnt_n;
    logic [GW-1:0]   gcnt_q, gcnt_n;

    // Round-robin search: first set req bit at or after rr_q, wrapping.
    logic            found;
    logic [IW-1:0]   win;
    logic [IW:0]     pos;
    logic [IW:0]     win_inc;
    logic [3:0]      win_size;
    logic [127:0]    win_bits;

    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = {1'b0, rr_q} + (IW+1)'(i);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!found && bus.req[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
        win_inc = {1'b0, win} + (IW+1)'(1);
        if (win_inc == (IW+1)'(NREQ)) begin
            win_inc = '0;
        end
        win_size = bus.req_size[{win, 2'b00} +: 4];
        win_bits = bus.req_bits[{win, 7'b0000000} +: 128];
    end

    always_comb begin
        state_n = state_q;
        tf_n    = 1'b0;
        size_n  = size_q;
        bits_n  = bits_q;
        ack_n   = '0;
        err_n   = 1'b0;
        gid_n   = gid_q;
        rr_n    = rr_q;
        tcnt_n  = tcnt_q;
        gcnt_n  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.stuffsend && found) begin
                    gid_n  = win;
                    rr_n   = win_inc[IW-1:0];
                    size_n = win_size;
                    bits_n = win_bits;
                    tcnt_n = '0;
                    gcnt_n = '0;
                    if (win_size == 4'd0) begin
                        ack_n[win] = 1'b1;
                        err_n      = 1'b1;
                        state_n    = GAP;
                    end else begin
                        state_n = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // stuffsend takes priority over an expiring timeout
                if (bus.stuffsend) begin
                    state_n = WAIT;
                end else if (tcnt_q == TMAX) begin
                    ack_n[gid_q] = 1'b1;
                    err_n        = 1'b1;
                    state_n      = GAP;
                end else begin
                    tcnt_n = tcnt_q + TW'(1);
                    tf_n   = 1'b1;
                end
            end
            WAIT: begin
                if (!bus.stuffsend) begin
                    ack_n[gid_q] = 1'b1;
                    state_n      = GAP;
                end
            end
            GAP: begin
                if (gcnt_q == GMAX) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt_q + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tf_q    <= 1'b0;
            size_q  <= '0;
            bits_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            rr_q    <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            tf_q    <= tf_n;
            size_q  <= size_n;
            bits_q  <= bits_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
            busy_q  <= busy_n;
            gid_q   <= gid_n;
            rr_q    <= rr_n;
            tcnt_q  <= tcnt_n;
            gcnt_q  <= gcnt_n;
        end
    end

    assign bus.tf        = tf_q;
    assign bus.framesize = size_q;
    assign bus.framebits = bits_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = gid_q;
endmodule
